// File: rtl/hv_query_sender.sv
// hv_query_sender: fuses three streamed modality hypervectors into a 2-of-3 majority query
// and offers it to the associative memory on a valid/ready handshake.
module hv_query_sender #(
  parameter int HV_DIMENSION = 2048,
  parameter int WORD_WIDTH = 32
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RBI,
  input  logic [WORD_WIDTH-1:0]   WordIn_DI,
  input  logic                    ValidIn_SI,
  output logic                    ReadyOut_SO,
  input  logic                    Flush_SI,
  output logic [0:HV_DIMENSION-1] HypervectorOut_DO,
  output logic                    ValidOut_SO,
  input  logic                    ReadyIn_SI,
  output logic                    OverflowErr_SO
);
  localparam int WORDS = HV_DIMENSION / WORD_WIDTH;
  localparam int CNT_W = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);
  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]              State_SP, State_SN;
  logic [CNT_W-1:0]        WordCnt_SP, WordCnt_SN;
  logic [1:0]              ModCnt_SP, ModCnt_SN;
  logic [0:HV_DIMENSION-1] Buf0_DP, Buf1_DP;
  logic                    Accept_S, LastWord_S;

  assign ReadyOut_SO = State_SP == LOAD;
  assign ValidOut_SO = State_SP == SEND;
  assign Accept_S    = ValidIn_SI && State_SP == LOAD && !Flush_SI;
  assign LastWord_S  = WordCnt_SP == LAST_WORD;

  always_comb begin
    State_SN   = State_SP;
    WordCnt_SN = WordCnt_SP;
    ModCnt_SN  = ModCnt_SP;
    if (State_SP == LOAD) begin
      if (Flush_SI) begin
        WordCnt_SN = '0;
        ModCnt_SN  = '0;
      end else if (ValidIn_SI) begin
        WordCnt_SN = LastWord_S ? '0 : WordCnt_SP + CNT_W'(1);
        if (LastWord_S) begin
          ModCnt_SN = ModCnt_SP == 2'd2 ? 2'd0 : ModCnt_SP + 2'd1;
          State_SN  = ModCnt_SP == 2'd2 ? SEND : LOAD;
        end
      end
    end else if (ReadyIn_SI) begin
      State_SN = LOAD;
    end
  end

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      State_SP       <= LOAD;
      WordCnt_SP     <= '0;
      ModCnt_SP      <= '0;
      OverflowErr_SO <= 1'b0;
    end else begin
      State_SP   <= State_SN;
      WordCnt_SP <= WordCnt_SN;
      ModCnt_SP  <= ModCnt_SN;
      if (State_SP == SEND && Flush_SI) OverflowErr_SO <= 1'b1;
    end
  end

  // Modality 2 is never buffered: each of its words is fused straight into the output slice.
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      Buf0_DP           <= '0;
      Buf1_DP           <= '0;
      HypervectorOut_DO <= '0;
    end else if (Accept_S) begin
      for (int k = 0; k < WORDS; k++) begin
        if (WordCnt_SP == CNT_W'(k)) begin
          if (ModCnt_SP == 2'd0) Buf0_DP[k*WORD_WIDTH +: WORD_WIDTH] <= WordIn_DI;
          if (ModCnt_SP == 2'd1) Buf1_DP[k*WORD_WIDTH +: WORD_WIDTH] <= WordIn_DI;
          if (ModCnt_SP == 2'd2)
            HypervectorOut_DO[k*WORD_WIDTH +: WORD_WIDTH] <=
              (Buf0_DP[k*WORD_WIDTH +: WORD_WIDTH] & Buf1_DP[k*WORD_WIDTH +: WORD_WIDTH]) |
              (Buf0_DP[k*WORD_WIDTH +: WORD_WIDTH] & WordIn_DI) |
              (Buf1_DP[k*WORD_WIDTH +: WORD_WIDTH] & WordIn_DI);
        end
      end
    end
  end
endmodule
